// File: rtl/unit3_1_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package unit3_1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  ADD3_TH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
  import unit3_1_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_i,
  output logic [DIGIT_W-1:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= ADD3_TH) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/unit3_1_fixed.sv
// Sequential binary-to-BCD converter, one input bit per clock, MSB first.
// Define UNIT3_1_RESTART_EN to let convierte restart a conversion in SHIFT.
//
// Handshake: convierte is accepted only on a rising edge where listo=1
// (state IDLE); fin pulses for one cycle when the new digits are on the
// outputs, and the digits then hold until the next completion.
module unit3_1_fixed
  import unit3_1_pkg::*;
#(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         convierte,
  input  logic [N-1:0] IN,
  output logic [3:0]   Rcentenas,
  output logic [3:0]   Rdecenas,
  output logic [3:0]   Runidades,
  output logic         fin,
  output logic         listo,
  output logic [1:0]   state_o
);

  localparam int BCD_W = 3 * DIGIT_W;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [N-1:0]       bits_q, bits_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   res_q, res_d;
  logic [BCD_W+N-1:0] shifted;
  logic               restart;
  logic               load;

  for (genvar g = 0; g < 3; g++) begin : g_digit
    bcd_add3 u_add3 (
      .d_i (bcd_q[g*DIGIT_W +: DIGIT_W]),
      .d_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign shifted = {bcd_adj, bits_q} << 1;

`ifdef UNIT3_1_RESTART_EN
  assign restart = (state_q == SHIFT) && convierte;
`else
  assign restart = 1'b0;
`endif

  assign load = ((state_q == IDLE) && convierte) || restart;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // The counter reaching 0 means all N shifts are done; that SHIFT cycle
  // only hands the finished digits over to the result register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (convierte) state_d = SHIFT;
      SHIFT:   if (!restart && (cnt_q == 4'd0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_d  = bcd_q;
    bits_d = bits_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    if (load) begin
      bits_d = IN;
      bcd_d  = '0;
      cnt_d  = 4'(N);
    end else if ((state_q == SHIFT) && (cnt_q != 4'd0)) begin
      bcd_d  = shifted[BCD_W+N-1:N];
      bits_d = shifted[N-1:0];
      cnt_d  = cnt_q - 4'd1;
    end
    if ((state_q == SHIFT) && !restart && (cnt_q == 4'd0)) res_d = bcd_q;
  end

  always_comb begin
    fin   = (state_q == DONE);
    listo = (state_q == IDLE);
  end

  assign state_o   = state_q;
  assign Rcentenas = res_q[11:8];
  assign Rdecenas  = res_q[7:4];
  assign Runidades = res_q[3:0];

endmodule

// File: tb/tb_unit3_1_fixed.sv
// Directed and sweep checks of unit3_1_fixed against a div/mod reference.
module tb_unit3_1_fixed;

  logic       clk;
  logic       rst;
  logic       convierte;
  logic [8:0] in_v;
  logic [3:0] rc, rd, ru;
  logic       fin, listo;
  logic [1:0] state_o;

  logic [11:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  unit3_1_fixed #(.N(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .convierte (convierte),
    .IN        (in_v),
    .Rcentenas (rc),
    .Rdecenas  (rd),
    .Runidades (ru),
    .fin       (fin),
    .listo     (listo),
    .state_o   (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drives one start pulse; returns at the falling edge after the accepting edge.
  task automatic start(input int v);
    @(negedge clk);
    in_v      = 9'(v);
    convierte = 1'b1;
    @(negedge clk);
    convierte = 1'b0;
  endtask

  task automatic wait_fin(input string tag, input int exp_lat);
    int lat;
    bit seen;
    logic [11:0] exp;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (fin) seen = 1'b1;
    end
    check({tag, "_fin_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_listo_in_done"}, 32'(listo), 32'd0);
      if (exp_q.size() == 0) begin
        check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check({tag, "_result"}, 32'({rc, rd, ru}), 32'(exp));
      end
      @(negedge clk);
      check({tag, "_fin_one_cycle"}, 32'(fin), 32'd0);
      check({tag, "_listo_back"}, 32'(listo), 32'd1);
    end
  endtask

  initial begin
    int fin_cnt;
    rst       = 1'b0;
    convierte = 1'b0;
    in_v      = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_fin", 32'(fin), 32'd0);
    check("reset_listo", 32'(listo), 32'd1);
    check("reset_digits", 32'({rc, rd, ru}), 32'd0);
    rst = 1'b1;

    // 19 -> 0/1/9
    exp_q.push_back(ref_bcd(19));
    start(19);
    check("busy_listo", 32'(listo), 32'd0);
    wait_fin("in19", 10);

    // 511 -> 5/1/1, previous result held while busy
    exp_q.push_back(ref_bcd(511));
    start(511);
    repeat (5) @(negedge clk);
    check("hold_during_conv", 32'({rc, rd, ru}), 32'h019);
    wait_fin("in511", 5);

    // Reset in the middle of a conversion
    start(511);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_listo", 32'(listo), 32'd1);
    check("abort_digits", 32'({rc, rd, ru}), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    fin_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (fin) fin_cnt++;
    end
    check("abort_no_fin", 32'(fin_cnt), 32'd0);
    check("abort_digits_after", 32'({rc, rd, ru}), 32'd0);
    check("abort_listo_after", 32'(listo), 32'd1);

    // Second start two cycles into a conversion
    exp_q.push_back(ref_bcd(19));
    start(19);
    @(negedge clk);
    in_v      = 9'd511;
    convierte = 1'b1;
`ifdef UNIT3_1_RESTART_EN
    void'(exp_q.pop_back());
    exp_q.push_back(ref_bcd(511));
`endif
    @(negedge clk);
    convierte = 1'b0;
    in_v      = 9'd0;
`ifdef UNIT3_1_RESTART_EN
    wait_fin("restart", 10);
`else
    wait_fin("ignore_start", 8);
`endif
    fin_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (fin) fin_cnt++;
    end
    check("single_fin", 32'(fin_cnt), 32'd0);

    // Boundary values
    exp_q.push_back(ref_bcd(0));
    start(0);
    wait_fin("in0", 10);
    exp_q.push_back(ref_bcd(100));
    start(100);
    wait_fin("in100", 10);
    check("in100_digits", 32'({rc, rd, ru}), 32'h100);

    // Full sweep with a random extra idle gap
    for (int v = 0; v < 512; v++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_q.push_back(ref_bcd(v));
      start(v);
      wait_fin("sweep", 10);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unit3_1_fixed.md
UNIT3_1_FIXED -- requirements
Module: unit3_1_fixed

Interface
REQ-001 SHALL have parameter N, default 9, the binary input width; legal range 4..9.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port convierte, input, 1 bit, the start-conversion request, sampled on clk.
REQ-005 SHALL have port IN, input, N bits, the unsigned binary value to convert, sampled on the accepted start edge.
REQ-006 SHALL have port Rcentenas, output, 4 bits, the BCD hundreds digit of the last completed result.
REQ-007 SHALL have port Rdecenas, output, 4 bits, the BCD tens digit of the last completed result.
REQ-008 SHALL have port Runidades, output, 4 bits, the BCD units digit of the last completed result.
REQ-009 SHALL have port fin, output, 1 bit, a one-cycle completion pulse.
REQ-010 SHALL have port listo, output, 1 bit, high when idle and able to accept convierte.

Function
REQ-011 SHALL implement sequential shift-and-add-3 (double dabble) conversion: one input bit per clock, MSB first.
REQ-012 SHALL use the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with convierte=1 at a rising edge, capture IN, clear the BCD working digits, load a shift counter with N, and go to SHIFT.
REQ-014 SHALL, in each SHIFT cycle, add 3 to any working digit >=5, then shift {digits, remaining bits} left by one and decrement the counter.
REQ-015 SHALL go from SHIFT to DONE after exactly N shifts.
REQ-016 SHALL, on entering DONE, register Rcentenas, Rdecenas and Runidades together, and assert fin for exactly that one cycle; DONE returns to IDLE unconditionally.
REQ-017 SHALL have a latency from the accepting edge to fin high of N+1 cycles (10 cycles for N=9).
REQ-018 SHALL drive listo=1 only in IDLE, and listo=0 in SHIFT and DONE.
REQ-019 SHALL hold the outputs Rcentenas, Rdecenas and Runidades stable between completions; intermediate working values never appear on them.
REQ-020 SHALL ignore convierte in SHIFT and DONE (default build); changes on IN after acceptance SHALL have no effect.
REQ-021 SHALL produce digits that are each always in the range 0..9, for the full input range 0..2^N-1.

Reset
REQ-022 SHALL, while rst=0 (asynchronous), force the state to IDLE, the counter and working registers to 0, Rcentenas, Rdecenas and Runidades to 0, fin to 0 and listo to 1.
REQ-023 SHALL, on reset during SHIFT, abort the conversion: no fin, and the outputs read 0.

Configuration
REQ-024 SHALL, when the macro UNIT3_1_RESTART_EN is defined, treat convierte=1 in SHIFT as a restart (recapture IN, reload the counter, clear the working digits; latency counted from the restart edge); when it is undefined, REQ-020 applies.

Structure
REQ-025 SHALL place in the shared package unit3_1_pkg: the state enum (IDLE, SHIFT, DONE), the digit width constant 4 and the correction threshold constant 5.
REQ-026 SHALL use the sub-module bcd_add3 (a combinational 4-bit digit: add 3 if >=5), instantiated once per digit (3 instances).

Verification
REQ-027 SHALL cover: reset for 3 cycles, then IN=19 with convierte pulsed for 1 cycle -> fin after 10 cycles, C=0 D=1 U=9, listo back to 1.
REQ-028 SHALL cover: IN=511 -> C=5 D=1 U=1, with fin high for exactly one cycle.
REQ-029 SHALL cover: IN=511 started, then rst low 5 cycles later -> no fin, outputs C=0 D=0 U=0, listo=1.
REQ-030 SHALL cover: IN=19 started, then IN=511 with convierte 2 cycles later (macro undefined) -> the single fin gives C=0 D=1 U=9.
REQ-031 SHALL cover: the same sequence with UNIT3_1_RESTART_EN defined -> fin 10 cycles after the second start, C=5 D=1 U=1.
REQ-032 SHALL cover: IN=0 and IN=100 -> 0/0/0 and 1/0/0; sweep all 512 values against a reference model.
